// File: rtl/bit_scan_queue.sv
// Sequential priority encoder: captures a request vector and emits one set-bit index per beat.
// Define BIT_SCAN_LSB_FIRST_EN to emit the lowest set index first instead of the highest.
module bit_scan_queue #(
    parameter int WIDTH = 16,
    localparam int IDXW = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDXW-1:0]   out_idx,
    output logic              out_none,
    output logic              out_last,
    output logic [IDXW:0]     count
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  vec_q, vec_d;
    logic              none_q, none_d;
    logic [IDXW-1:0]   scan_idx;
    logic [IDXW:0]     pending;
    logic              emitting;
    logic              pop;
    logic              load;

    function automatic logic [IDXW-1:0] priority_idx(input logic [WIDTH-1:0] v);
        logic [IDXW-1:0] idx;
        idx = {IDXW{1'b0}};
`ifdef BIT_SCAN_LSB_FIRST_EN
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = i[IDXW-1:0];
            end else begin
                idx = idx;
            end
        end
`else
        for (int i = 0; i < WIDTH; i++) begin
            if (v[i]) begin
                idx = i[IDXW-1:0];
            end else begin
                idx = idx;
            end
        end
`endif
        return idx;
    endfunction

    function automatic logic [IDXW:0] popcount(input logic [WIDTH-1:0] v);
        logic [IDXW:0] c;
        c = {(IDXW+1){1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            c = c + {{IDXW{1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Output fields derive from registers only; in_ready also honours reset and flush.
    always_comb begin
        emitting  = (state_q == EMIT);
        scan_idx  = priority_idx(vec_q);
        pending   = popcount(vec_q);
        out_valid = emitting;
        out_none  = emitting & none_q;
        out_idx   = (emitting && !none_q) ? scan_idx : {IDXW{1'b0}};
        count     = emitting ? pending : {(IDXW+1){1'b0}};
        out_last  = emitting && (pending <= {{IDXW{1'b0}}, 1'b1});
        in_ready  = rst_n & ~flush & (~emitting | (out_ready & out_last));
        pop       = out_valid & out_ready;
        load      = in_valid & in_ready;
    end

    // Next state: flush beats load, load beats the end-of-vector return to IDLE.
    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        none_d  = none_q;
        if (flush) begin
            state_d = IDLE;
            vec_d   = {WIDTH{1'b0}};
            none_d  = 1'b0;
        end else begin
            if (pop) begin
                vec_d[out_idx] = 1'b0;
                if (out_last) begin
                    state_d = IDLE;
                    none_d  = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end else begin
                vec_d = vec_q;
            end
            if (load) begin
                state_d = EMIT;
                vec_d   = in_vec;
                none_d  = (in_vec == {WIDTH{1'b0}});
            end else begin
                none_d = none_d;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            vec_q   <= {WIDTH{1'b0}};
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            none_q  <= none_d;
        end
    end

endmodule

// File: tb/tb_bit_scan_queue.sv
// Self-checking bench for bit_scan_queue: directed test-plan sequences then random traffic
// compared each cycle against a queue-based reference model.
module tb_bit_scan_queue;

    localparam int WIDTH = 16;
    localparam int IDXW  = 4;

    logic              clk;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_vec;
    logic              out_valid;
    logic              out_ready;
    logic [IDXW-1:0]   out_idx;
    logic              out_none;
    logic              out_last;
    logic [IDXW:0]     count;

    int n_vectors = 0;
    int n_miscompares = 0;

    // Reference model: pending indices in emission order, plus busy / zero-vector flags.
    int m_q[$];
    bit m_busy = 1'b0;
    bit m_none = 1'b0;

    bit_scan_queue #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_vec    (in_vec),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_idx   (out_idx),
        .out_none  (out_none),
        .out_last  (out_last),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vectors++;
        if (obs !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_busy = 1'b0;
        m_none = 1'b0;
    endtask

    task automatic model_load(input logic [WIDTH-1:0] v);
        m_q.delete();
`ifdef BIT_SCAN_LSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) if (v[i]) m_q.push_back(i);
`else
        for (int i = WIDTH - 1; i >= 0; i--) if (v[i]) m_q.push_back(i);
`endif
        m_busy = 1'b1;
        m_none = (m_q.size() == 0);
    endtask

    // One clock cycle: drive at negedge, check outputs, advance model at posedge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [WIDTH-1:0] v, input logic ordy);
        bit exp_last;
        bit exp_ready;
        int exp_idx;
        rst_n = r; flush = f; in_valid = iv; in_vec = v; out_ready = ordy;
        #1;
        exp_last  = m_busy && (m_none || m_q.size() <= 1);
        exp_ready = r && !f && (!m_busy || (ordy && exp_last));
        exp_idx   = (m_busy && !m_none) ? m_q[0] : 0;
        check_eq("in_ready",  {31'd0, in_ready},  {31'd0, exp_ready});
        check_eq("out_valid", {31'd0, out_valid}, {31'd0, m_busy});
        check_eq("out_idx",   {28'd0, out_idx},   exp_idx);
        check_eq("out_none",  {31'd0, out_none},  {31'd0, (m_busy && m_none)});
        check_eq("out_last",  {31'd0, out_last},  {31'd0, exp_last});
        check_eq("count",     {27'd0, count},     m_q.size());
        @(posedge clk);
        if (!r || f) begin
            model_clear();
        end else begin
            if (m_busy && ordy) begin
                if (exp_last) model_clear();
                else void'(m_q.pop_front());
            end
            if (iv && exp_ready) model_load(v);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [WIDTH-1:0] rv;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_vec = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        model_clear();

        // Reset state, then 0x8001 at full throughput.
        step(1'b1, 1'b0, 1'b1, 16'h8001, 1'b1);
`ifdef BIT_SCAN_LSB_FIRST_EN
        check_eq("first_idx_8001", {28'd0, out_idx}, 32'd0);
`else
        check_eq("first_idx_8001", {28'd0, out_idx}, 32'd15);
`endif
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Zero vector gives one out_none beat.
        step(1'b1, 1'b0, 1'b1, 16'h0000, 1'b1);
        check_eq("zero_none", {31'd0, out_none}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Stall for three cycles with 0x0024.
        step(1'b1, 1'b0, 1'b1, 16'h0024, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Back-to-back: 0x0003 then 0x0100 loaded during the last pop.
        step(1'b1, 1'b0, 1'b1, 16'h0003, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'h0100, 1'b1);
        check_eq("b2b_valid", {31'd0, out_valid}, 32'd1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Abort mid-vector with flush, then with reset; in_valid in the same cycle is dropped.
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
        check_eq("flush_idle", {31'd0, out_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b1, 1'b0, 1'b1, 16'hFFFF, 1'b1);
        repeat (3) step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);
        step(1'b0, 1'b1, 1'b1, 16'h1234, 1'b1);
        check_eq("reset_idle", {27'd0, count}, 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            case ($urandom_range(0, 3))
                0: rv = 16'h0000;
                1: rv = 16'h0001 << $urandom_range(0, WIDTH - 1);
                2: rv = 16'($urandom());
                default: rv = 16'($urandom()) & 16'($urandom());
            endcase
            step(($urandom_range(0, 59) != 0), ($urandom_range(0, 29) == 0),
                 ($urandom_range(0, 1) == 1), rv, ($urandom_range(0, 9) < 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/bit_scan_queue.md
# bit_scan_queue

Parametrised, sequential priority encoder that captures a WIDTH-bit request vector and emits the index of every set bit, one per handshake beat, in priority order (highest index first by default). It replaces the single-shot combinational "first set bit" encoder in the tt_um_group1 datapath wherever all asserted requests must be serviced in turn, not only the top one. Valid/ready handshakes on both sides allow it to sit between an input sampler and a downstream consumer that may stall.

## Interface
- WIDTH, 16, request vector width (≥2); IDXW = $clog2(WIDTH) is a derived localparam
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  reset, synchronous and active-low
- flush  input  1  synchronous abort of the vector in progress
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector this cycle
- in_vec  input  WIDTH  request vector
- out_valid  output  1  out_idx/out_none/out_last are valid
- out_ready  input  1  consumer accepts the current beat
- out_idx  output  IDXW  index of the current highest-priority set bit
- out_none  output  1  the captured vector was all zeros
- out_last  output  1  current beat is the last one for this vector
- count  output  IDXW+1  set bits still pending in the held vector, including the current beat

## Operation
- Two states: IDLE and EMIT. Registers: state, vec[WIDTH-1:0], none_flag.
- IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, vec<=in_vec, none_flag<=(in_vec==0), state<=EMIT.
- EMIT: out_valid=1. out_idx = highest set bit of vec, or 0 if none_flag. out_last = (count<=1). out_none = none_flag.
- Pop: on out_valid&&out_ready, clear bit out_idx in vec. If out_last, go to IDLE, unless a new vector is accepted in the same cycle.
- in_ready = (state==IDLE) | (state==EMIT & out_ready & out_last). Loading in EMIT replaces vec and stays in EMIT, with no bubble.
- Zero vector: exactly one beat with out_none=1, out_idx=0, out_last=1, count=0.
- count = popcount(vec); it is 0 in IDLE.
- flush (when rst_n=1): state<=IDLE, vec<=0, none_flag<=0. Any in_valid or out handshake in the same cycle is ignored. flush overrides load and pop.
- in_ready is forced to 0 while flush=1 or rst_n=0.
- Reset (rst_n=0 at an edge): state=IDLE, vec=0, none_flag=0. Reset overrides flush, load and pop, and is honoured in any state, including mid-vector.

## Timing
- Load-to-first-beat latency: 1 cycle. Vector accepted at edge T gives out_valid=1 in the cycle after T.
- A vector with k set bits occupies max(k,1) accepted beats. Full throughput is one beat per cycle with out_ready held at 1.
- Back-to-back vectors: a load in the last-pop cycle yields the new vector's first beat on the next cycle.
- out_idx, out_none, out_last and count come combinationally from registers only. They do not depend on in_* or out_ready.
- While out_valid=1 and out_ready=0, all output fields hold stable.
- Outputs after reset: in_ready=1 (once rst_n=1), out_valid=0, out_idx=0, out_none=0, out_last=0, count=0.

## Configuration
- BIT_SCAN_LSB_FIRST_EN defined: priority is lowest set index first; out_idx = lowest set bit of vec.
- Not defined: highest set index first (default).
- Handshake, count, out_none and out_last behaviour are identical in both builds.

## Test plan
- WIDTH=16, reset then load 0x8001 with out_ready=1 -> beats idx=15 (count=2, last=0), then idx=0 (count=1, last=1), then IDLE with in_ready=1.
- Load 0x0000 -> single beat out_none=1, idx=0, last=1, count=0, then in_ready=1.
- Load 0x0024, hold out_ready=0 for 3 cycles -> idx=5 stable with out_valid=1 for 3 cycles. Release -> idx=5, then idx=2 (last=1).
- Back-to-back: 0x0003 then 0x0100 with in_valid presented during the last pop -> beats 1, 0, 8 on consecutive cycles, no bubble.
- Load 0xFFFF, pop 3 beats (15, 14, 13), assert flush together with in_valid=1 -> next cycle out_valid=0, count=0, in_ready=1, no vector captured. Repeat with rst_n=0 instead of flush -> same result.
- BIT_SCAN_LSB_FIRST_EN build: load 0x8001 -> idx=0 (last=0), then idx=15 (last=1).
